// File: rtl/secded_pkg.sv
// secded_pkg: codeword geometry, Hamming bit positions and controller states for the SECDED scrubber.
package secded_pkg;
  localparam int CW_W = 8;
  localparam int DW = 4;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  localparam int PB = 7;
  typedef enum logic [2:0] {IDLE, WAIT, S_RD, S_CHK, S_WB, H_RD, H_CHK} state_t;
endpackage

// File: rtl/secded74_codec.sv
// secded74_codec: combinational Hamming(7,4)+overall-parity encoder and single-correct/double-detect decoder.
module secded74_codec
  import secded_pkg::*;
(
  input  logic [DW-1:0]   i_data,
  output logic [CW_W-1:0] o_code,
  input  logic [CW_W-1:0] i_code,
  output logic [DW-1:0]   o_data,
  output logic [CW_W-1:0] o_fixed,
  output logic            o_err1,
  output logic            o_err2
);
  logic [6:0] h;
  logic [2:0] s;
  logic       p;
  always_comb begin
    h = '0;
    h[D0] = i_data[0];
    h[D1] = i_data[1];
    h[D2] = i_data[2];
    h[D3] = i_data[3];
    h[P1] = i_data[0] ^ i_data[1] ^ i_data[3];
    h[P2] = i_data[0] ^ i_data[2] ^ i_data[3];
    h[P4] = i_data[1] ^ i_data[2] ^ i_data[3];
  end
  assign o_code = {^h, h};
  assign s = {i_code[P4] ^ i_code[D1] ^ i_code[D2] ^ i_code[D3],
              i_code[P2] ^ i_code[D0] ^ i_code[D2] ^ i_code[D3],
              i_code[P1] ^ i_code[D0] ^ i_code[D1] ^ i_code[D3]};
  assign p = ^i_code;
  // Odd overall parity means one flipped bit: syndrome names it, zero syndrome blames the parity bit itself.
  assign o_fixed = i_code ^ (!p ? 8'h00 : (s == 3'd0 ? 8'h01 << PB : 8'h01 << (s - 3'd1)));
  assign o_data = {o_fixed[D3], o_fixed[D2], o_fixed[D1], o_fixed[D0]};
  assign o_err1 = p;
  assign o_err2 = !p && s != 3'd0;
endmodule

// File: rtl/secded_scrubber.sv
// secded_scrubber: arbitrates one SECDED-protected memory between host accesses and a periodic background scrubber.
module secded_scrubber
  import secded_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INTERVAL = 16,
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DW-1:0]     i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,
  output logic [DW-1:0]     o_host_rdata,
  output logic              o_host_err1,
  output logic              o_host_err2,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [CW_W-1:0]   o_mem_wdata,
  input  logic [CW_W-1:0]   i_mem_rdata,
  input  logic              i_clr_status,
  output logic [CNT_W-1:0]  o_corr_cnt,
  output logic [CNT_W-1:0]  o_uncorr_cnt,
  output logic              o_uncorr_valid,
  output logic [ADDR_W-1:0] o_uncorr_addr,
  output logic              o_pass_done,
  output logic              o_busy
);
  localparam int IW = INTERVAL > 1 ? $clog2(INTERVAL) : 1;
  state_t            state_q, state_d, back;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ua_q, ua_d;
  logic [CW_W-1:0]   wb_q, wb_d, enc, fixed;
  logic [DW-1:0]     rdata_q, rdata_d, dec;
  logic [CNT_W-1:0]  corr_q, corr_d, uncorr_q, uncorr_d;
  logic              rvalid_q, rvalid_d, err1_q, err1_d, err2_q, err2_d;
  logic              uv_q, uv_d, pd_q, pd_d, e1, e2, host_ok, step_done;
  secded74_codec u_codec (
    .i_data(i_host_wdata), .o_code(enc), .i_code(i_mem_rdata),
    .o_data(dec), .o_fixed(fixed), .o_err1(e1), .o_err2(e2)
  );
  assign host_ok = (state_q == IDLE || state_q == WAIT) && i_host_req;
  assign back = i_enable ? WAIT : IDLE;
  assign o_host_gnt = host_ok;
  assign o_mem_en = host_ok || state_q == S_RD || state_q == S_WB;
  assign o_mem_we = (host_ok && i_host_we) || state_q == S_WB;
  assign o_mem_addr = host_ok ? i_host_addr : addr_q;
  assign o_mem_wdata = !o_mem_we ? '0 : host_ok ? enc : wb_q;
  assign o_host_rvalid = rvalid_q;
  assign o_host_rdata = rdata_q;
  assign o_host_err1 = err1_q;
  assign o_host_err2 = err2_q;
  assign o_corr_cnt = corr_q;
  assign o_uncorr_cnt = uncorr_q;
  assign o_uncorr_valid = uv_q;
  assign o_uncorr_addr = ua_q;
  assign o_pass_done = pd_q;
  assign o_busy = !(state_q == IDLE || state_q == WAIT);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wb_d = wb_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    err1_d = 1'b0;
    err2_d = 1'b0;
    pd_d = 1'b0;
    corr_d = corr_q;
    uncorr_d = uncorr_q;
    uv_d = uv_q;
    ua_d = ua_q;
    step_done = 1'b0;
    unique case (state_q)
      IDLE, WAIT:
        if (host_ok) state_d = i_host_we ? back : H_RD;
        else if (state_q == IDLE || !i_enable) state_d = back;
        else if (cnt_q == IW'(INTERVAL - 1)) begin
          state_d = S_RD;
          cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      S_RD: state_d = S_CHK;
      S_CHK: begin
        wb_d = fixed;
        if (e1) begin
          state_d = S_WB;
          corr_d = corr_q + CNT_W'(~&corr_q);
        end else begin
          step_done = 1'b1;
          if (e2) begin
            uncorr_d = uncorr_q + CNT_W'(~&uncorr_q);
            uv_d = 1'b1;
            ua_d = uv_q ? ua_q : addr_q;
          end
        end
      end
      S_WB: step_done = 1'b1;
      H_RD: begin
        state_d = H_CHK;
        rvalid_d = 1'b1;
        rdata_d = dec;
        err1_d = e1;
        err2_d = e2;
      end
      H_CHK: state_d = back;
      default: state_d = IDLE;
    endcase
    if (step_done) begin
      addr_d = addr_q + 1'b1;
      pd_d = &addr_q;
      state_d = back;
    end
    if (state_d == IDLE) cnt_d = '0;
    // Clearing beats any same-cycle increment or capture.
    if (i_clr_status) begin
      corr_d = '0;
      uncorr_d = '0;
      uv_d = 1'b0;
      ua_d = '0;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wb_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      err1_q <= 1'b0;
      err2_q <= 1'b0;
      pd_q <= 1'b0;
      corr_q <= '0;
      uncorr_q <= '0;
      uv_q <= 1'b0;
      ua_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wb_q <= wb_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      err1_q <= err1_d;
      err2_q <= err2_d;
      pd_q <= pd_d;
      corr_q <= corr_d;
      uncorr_q <= uncorr_d;
      uv_q <= uv_d;
      ua_q <= ua_d;
    end
  end
endmodule

// File: tb/tb_secded_scrubber.sv
// tb_secded_scrubber: table, random and corner-sequence checks of the scrubber against a nearest-codeword reference.
module tb_secded_scrubber;
  logic clk = 0, rst = 1, en = 0, req = 0, hwe = 0, clr = 0, en1 = 0, clr1 = 0;
  logic [3:0] haddr = 0, hwd = 0;
  logic [7:0] r1 = 0, mrd = 0;
  logic gnt, rvalid, e1, e2, men, mwe, uv, pd, busy;
  logic [3:0] rdata, maddr, ua;
  logic [7:0] mwd, corr, uncorr;
  logic gnt1, rvalid1, e1_1, e2_1, men1, mwe1, uv1, pd1, busy1;
  logic [3:0] rdata1;
  logic [1:0] maddr1, ua1, corr1, uncorr1;
  logic [7:0] mwd1;
  logic [7:0] mem[16];
  logic mclr = 0, poke_en = 0;
  logic [3:0] pa = 0;
  logic [7:0] pv = 0;
  int wcnt = 0;
  logic [3:0] waddr;
  logic [7:0] wdat;
  int total = 0, bad = 0;
  logic c_en, c_we, c_v1, c_v, c_e1, c_e2;
  logic [3:0] c_addr, c_rd;
  logic [7:0] c_wd;

  always #5 clk = ~clk;

  secded_scrubber u0 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_host_req(req), .i_host_we(hwe),
    .i_host_addr(haddr), .i_host_wdata(hwd), .o_host_gnt(gnt), .o_host_rvalid(rvalid),
    .o_host_rdata(rdata), .o_host_err1(e1), .o_host_err2(e2), .o_mem_en(men), .o_mem_we(mwe),
    .o_mem_addr(maddr), .o_mem_wdata(mwd), .i_mem_rdata(mrd), .i_clr_status(clr),
    .o_corr_cnt(corr), .o_uncorr_cnt(uncorr), .o_uncorr_valid(uv), .o_uncorr_addr(ua),
    .o_pass_done(pd), .o_busy(busy)
  );

  secded_scrubber #(.ADDR_W(2), .INTERVAL(1), .CNT_W(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en1), .i_host_req(1'b0), .i_host_we(1'b0),
    .i_host_addr(2'd0), .i_host_wdata(4'd0), .o_host_gnt(gnt1), .o_host_rvalid(rvalid1),
    .o_host_rdata(rdata1), .o_host_err1(e1_1), .o_host_err2(e2_1), .o_mem_en(men1), .o_mem_we(mwe1),
    .o_mem_addr(maddr1), .o_mem_wdata(mwd1), .i_mem_rdata(r1), .i_clr_status(clr1),
    .o_corr_cnt(corr1), .o_uncorr_cnt(uncorr1), .o_uncorr_valid(uv1), .o_uncorr_addr(ua1),
    .o_pass_done(pd1), .o_busy(busy1)
  );

  always @(posedge clk) begin
    if (mclr) for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    else if (poke_en) mem[pa] <= pv;
    else if (men && mwe) mem[maddr] <= mwd;
    if (men && !mwe) mrd <= mem[maddr];
    if (men && mwe) begin
      wcnt <= wcnt + 1;
      waddr <= maddr;
      wdat <= mwd;
    end
  end

  function automatic int dpos(input int i);
    return i == 0 ? 3 : i == 1 ? 5 : i == 2 ? 6 : 7;
  endfunction

  // Places data at positions 3,5,6,7, then each power-of-two position covers the positions sharing its bit.
  function automatic logic [7:0] ref_enc(input logic [3:0] d);
    logic [7:0] c = '0;
    for (int i = 0; i < 4; i++) c[dpos(i)-1] = d[i];
    for (int p = 1; p < 8; p = p * 2)
      for (int k = 1; k < 8; k++) if (k != p && (k & p) != 0) c[p-1] = c[p-1] ^ c[k-1];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Returns {err2, err1, data}: nearest valid codeword at distance 0 or 1, otherwise raw data bits.
  function automatic logic [5:0] ref_dec(input logic [7:0] c);
    for (int v = 0; v < 16; v++) begin
      if ($countones(ref_enc(4'(v)) ^ c) == 0) return {2'b00, 4'(v)};
      if ($countones(ref_enc(4'(v)) ^ c) == 1) return {2'b01, 4'(v)};
    end
    return {2'b10, c[6], c[5], c[4], c[2]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {gnt, rvalid, rdata, e1, e2, men, mwe, maddr, mwd, corr, uncorr, uv, ua, pd, busy}, 64'd0);
  endtask

  task automatic host(input logic we, input logic [3:0] a, input logic [3:0] d, output int n);
    req = 1; hwe = we; haddr = a; hwd = d; n = 0;
    #1;
    while (!gnt && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("host_gnt", gnt, 1);
    c_en = men; c_we = mwe; c_addr = maddr; c_wd = mwd;
    @(posedge clk); #1; req = 0;
    if (!we) begin
      c_v1 = rvalid;
      @(posedge clk); #1;
      c_v = rvalid; c_rd = rdata; c_e1 = e1; c_e2 = e2;
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] v);
    @(negedge clk); poke_en = 1; pa = a; pv = v;
    @(posedge clk); #1; poke_en = 0;
  endtask

  task automatic clear_mem();
    @(negedge clk); mclr = 1;
    @(posedge clk); #1; mclr = 0;
  endtask

  task automatic wait_srd(input string nm);
    int n = 0;
    while (!(men && !gnt) && n < 200) begin
      @(negedge clk); n++;
    end
    chk(nm, men && !gnt, 1);
  endtask

  typedef struct {
    logic [3:0] d;
    logic [7:0] flip;
    logic [7:0] code;
    logic [3:0] rd;
    logic x1;
    logic x2;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, w0;
    logic [3:0] shadow[16];
    logic [7:0] flip[16];
    logic [5:0] x;
    tbl[0] = '{4'hB, 8'h00, 8'h55, 4'hB, 1'b0, 1'b0};
    tbl[1] = '{4'hB, 8'h04, 8'h55, 4'hB, 1'b1, 1'b0};
    tbl[2] = '{4'hB, 8'h80, 8'h55, 4'hB, 1'b1, 1'b0};
    tbl[3] = '{4'hB, 8'h14, 8'h55, 4'h8, 1'b0, 1'b1};
    tbl[4] = '{4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
    tbl[5] = '{4'hF, 8'h00, 8'hFF, 4'hF, 1'b0, 1'b0};
    tbl[6] = '{4'h1, 8'h01, 8'h87, 4'h1, 1'b1, 1'b0};
    tbl[7] = '{4'hF, 8'h48, 8'hFF, 4'h7, 1'b0, 1'b1};
    tbl[8] = '{4'h0, 8'h81, 8'h00, 4'h0, 1'b0, 1'b1};
    clear_mem();
    repeat (2) @(negedge clk);
    chk_zero("reset_u0");
    chk("reset_u1", {men1, pd1, busy1, corr1, uv1, rvalid1}, 0);
    rst = 0;
    foreach (tbl[i]) begin
      @(negedge clk);
      host(1, 4'd2, tbl[i].d, n);
      chk("tbl_wr_en", {c_en, c_we, c_addr}, {2'b11, 4'd2});
      chk("tbl_wr_code", c_wd, tbl[i].code);
      if (tbl[i].flip != 0) poke(4'd2, tbl[i].code ^ tbl[i].flip);
      @(negedge clk);
      host(0, 4'd2, 4'd0, n);
      chk("tbl_rd_strobe", {c_en, c_we}, 2'b10);
      chk("tbl_rvalid_early", c_v1, 0);
      chk("tbl_rvalid", c_v, 1);
      chk("tbl_rdata", c_rd, tbl[i].rd);
      chk("tbl_errs", {c_e1, c_e2}, {tbl[i].x1, tbl[i].x2});
    end
    clear_mem();
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 0;
      flip[i] = 0;
    end
    for (int k = 0; k < 80; k++) begin
      logic [3:0] a, d;
      logic [7:0] m;
      a = 4'($urandom_range(0, 15));
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        d = 4'($urandom);
        host(1, a, d, n);
        chk("rnd_wr_code", {c_we, c_addr, c_wd}, {1'b1, a, ref_enc(d)});
        shadow[a] = d;
        flip[a] = 0;
        if ($urandom_range(0, 2) == 0) begin
          m = 8'h01 << $urandom_range(0, 7);
          if ($urandom_range(0, 1) == 1) m = m | (8'h01 << $urandom_range(0, 7));
          flip[a] = m;
          poke(a, ref_enc(d) ^ m);
        end
      end else begin
        host(0, a, 4'd0, n);
        x = ref_dec(ref_enc(shadow[a]) ^ flip[a]);
        chk("rnd_rd", {c_v, c_e2, c_e1, c_rd}, {1'b1, x});
      end
    end
    @(negedge clk); rst = 1;
    clear_mem();
    poke(4'd5, 8'h51);
    poke(4'd7, 8'h56);
    poke(4'd9, 8'h56);
    @(negedge clk); rst = 0; w0 = wcnt; en = 1;
    n = 0;
    while (!pd && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("pass_done_u0", pd, 1);
    chk("scrub_writes", wcnt - w0, 1);
    chk("scrub_wb", {waddr, wdat}, {4'd5, 8'h55});
    chk("scrub_mem", {mem[5], mem[7], mem[9]}, {8'h55, 8'h56, 8'h56});
    chk("scrub_cnts", {corr, uncorr}, {8'd1, 8'd2});
    chk("uncorr_sticky", {uv, ua}, {1'b1, 4'd7});
    @(negedge clk);
    host(1, 4'd2, 4'h6, n);
    chk("wait_wr", mem[2], 8'h06 ^ ref_enc(4'h6) ^ 8'h06);
    @(negedge clk);
    wait_srd("srd_seen");
    host(0, 4'd2, 4'd0, n);
    chk("gnt_delay", n, 2);
    chk("srd_rd", {c_v1, c_v, c_e1, c_e2, c_rd}, {4'b0100, 4'h6});
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    chk("clr_u0", {corr, uncorr, uv}, 0);
    @(negedge clk); rst = 1; en = 0;
    clear_mem();
    poke(4'd0, 8'h51);
    @(negedge clk); rst = 0; en = 1;
    wait_srd("srd_rst");
    chk("srd_rst_addr", maddr, 0);
    @(negedge clk);
    rst = 1; w0 = wcnt;
    #1 chk_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 0;
    chk("no_wb_on_reset", {wcnt - w0, 24'(mem[0])}, {32'd0, 24'h51});
    wait_srd("srd_resume");
    chk("resume_addr", maddr, 0);
    n = 0;
    while (wcnt == w0 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("resume_wb", {waddr, wdat}, {4'd0, 8'h55});
    en = 0;
    @(negedge clk); en1 = 1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!men1 && n < 20) begin
        @(negedge clk); n++;
      end
      chk("p_addr", {men1, maddr1}, {1'b1, 2'(i)});
      if (i < 3) chk("p_early", pd1, 0);
      @(negedge clk);
    end
    n = 0;
    while (!pd1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("pd1_pulse", pd1, 1);
    @(negedge clk);
    chk("pd1_width", pd1, 0);
    n = 0;
    while (!men1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("wrap_addr", {men1, maddr1}, 3'b100);
    r1 = 8'h51; clr1 = 1;
    repeat (20) @(negedge clk);
    chk("clr_wins", {corr1, uncorr1, uv1}, 0);
    clr1 = 0;
    repeat (40) @(negedge clk);
    chk("corr_sat", {corr1, uncorr1}, {2'd3, 2'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/secded_scrubber.md
# secded_scrubber

Controller that owns a single-port memory of SECDED Hamming(7,4)+parity codewords and shares it between a host port and a background scrubber. Host writes are encoded; host reads are decoded, corrected and flagged. When enabled, it periodically walks every address, rewrites single-bit-corrupted words and records uncorrectable ones. It sits between the system bus and the protected memory macro.

## Interface
- ADDR_W, 4, memory address width (2^ADDR_W codewords)
- INTERVAL, 16, idle cycles between scrub steps (≥1)
- CNT_W, 8, error counter width
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  scrubber enable
- i_host_req  in  1  host request, held until grant
- i_host_we  in  1  1 = write, 0 = read
- i_host_addr  in  ADDR_W  host address
- i_host_wdata  in  4  host write data
- o_host_gnt  out  1  one-cycle pulse: request accepted
- o_host_rvalid  out  1  one-cycle pulse: read result valid
- o_host_rdata  out  4  corrected read data
- o_host_err1 / o_host_err2  out  1 each  read had single (corrected) / double error
- o_mem_en, o_mem_we  out  1 each  memory strobe / write
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  8  codeword to write
- i_mem_rdata  in  8  codeword, valid the cycle after a read strobe
- i_clr_status  in  1  clears counters and sticky flag
- o_corr_cnt, o_uncorr_cnt  out  CNT_W each  saturating scrub error counts
- o_uncorr_valid  out  1  sticky: an uncorrectable word was found
- o_uncorr_addr  out  ADDR_W  address of first uncorrectable word since clear
- o_pass_done  out  1  one-cycle pulse: last address scrubbed
- o_busy  out  1  state is not IDLE/WAIT

## Operation
- Codeword: bits[6:0] = Hamming positions 1..7 (bit0 = pos1); p1=pos1, p2=pos2, p4=pos4, d0=pos3, d1=pos5, d2=pos6, d3=pos7; p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3; bit7 = XOR of bits[6:0].
- Decode: syndrome s={s4,s2,s1}, P = XOR of all 8 bits. s=0,P=0 clean; P=1 single error (s≠0 flip pos s, s=0 bit7 bad), err1; s≠0,P=0 double, err2, data passed uncorrected.
- States: IDLE, WAIT, S_RD, S_CHK, S_WB, H_RD, H_CHK.
- IDLE: i_enable=1 -> WAIT. WAIT: interval counter counts to INTERVAL-1 -> S_RD; i_enable=0 -> IDLE, counter cleared.
- Host arbitration: in IDLE or WAIT a pending i_host_req wins over scrubbing; grant cycle drives memory. Write: encode, o_mem_we=1, stay/return to IDLE/WAIT (counter held). Read: -> H_RD (data arrives) -> H_CHK registers outputs -> back. Host never granted in S_RD/S_CHK/S_WB.
- S_RD: read scrub_addr. S_CHK: decode. err1 -> S_WB writes corrected re-encoded word, corr_cnt++; err2 -> uncorr_cnt++, capture address if sticky clear, set sticky; clean -> no write. Then scrub_addr++ (wraps at 2^ADDR_W-1, pulsing o_pass_done) -> WAIT (or IDLE if i_enable=0).
- i_enable falling mid-step: step completes, then IDLE.
- Counters saturate at all-ones. i_clr_status same cycle as increment: clear wins.

## Timing
- Reset: all outputs 0, state IDLE, scrub_addr 0, interval counter 0, counters 0, sticky 0.
- Host write: request seen cycle t -> gnt and memory write at t (if IDLE/WAIT).
- Host read: gnt + read strobe at t, i_mem_rdata at t+1, o_host_rvalid/rdata/err at t+2.
- Scrub step: read t, decode t+1, optional write-back t+2; host waits up to 3 cycles.
- Reset mid-step aborts without write-back.

## Structure
- Package secded_pkg: codeword width (8), data width (4), bit-position constants, state enum.
- Sub-module secded74_codec: combinational encode + decode (corrected data, corrected codeword, err1, err2); one instance shared by host and scrub paths.

## Test plan
- Host write 4'hB @ addr 2 -> o_mem_wdata=8'h55 with we; host read -> rdata=4'hB, err1=0, err2=0 two cycles after gnt.
- Preload addr 5 with 8'h51 (bit2 flipped), enable scrub -> S_WB writes 8'h55 to addr 5, corr_cnt=1.
- Preload addr 7 with 8'h56 -> no write-back, uncorr_cnt=1, o_uncorr_valid=1, o_uncorr_addr=7; second bad word at addr 9 keeps addr 7.
- Host read request asserted in S_RD -> gnt delayed until WAIT; rvalid two cycles later with correct data.
- INTERVAL=1, ADDR_W=2, clean memory -> o_pass_done pulses after address 3, scrub_addr returns to 0; i_clr_status with pending increment leaves counts 0.
- Assert i_rst during S_CHK of an erroneous word -> no write, all outputs 0, resumes from addr 0.
